// File: rtl/control_acceso_pkg.sv
// -----------------------------------------------------------------------------
// control_acceso_pkg
// Purpose : shared definitions for the parking-gate access controller.
//           Holds the FSM state encoding and the default parameter values
//           used by control_acceso_param and registro_clave.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package control_acceso_pkg;

  // Controller states. IDLE is the all-zero code so that reset and
  // "nothing happening" share one encoding.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INGRESO    = 3'd1,
    ST_ABIERTO    = 3'd2,
    ST_BLOQUEO    = 3'd3,
    ST_ALARMA_PIN = 3'd4
  } state_t;

  // Default configuration.
  localparam int         DEF_PW_BITS        = 8;
  localparam logic [7:0] DEF_PASSWORD       = 8'b0011_1111;
  localparam int         DEF_MAX_INTENTOS   = 3;
  localparam int         DEF_TIMEOUT_CICLOS = 16;

endpackage : control_acceso_pkg

// File: rtl/control_acceso_param_registro_clave.sv
// -----------------------------------------------------------------------------
// registro_clave
// Purpose : serial password receiver. Shifts one bit per enabled cycle (MSB
//           first), counts received bits and flags the cycle in which the
//           last bit of a word arrives, together with whether the complete
//           word equals PASSWORD.
// Ports   :
//   i_clk       in   system clock, rising edge
//   i_rst_n     in   asynchronous active-low reset
//   i_clear     in   synchronous clear of shift register and bit counter
//   i_shift_en  in   consume i_bit this cycle
//   i_bit       in   serial password bit
//   o_complete  out  this enabled cycle delivers the final bit of a word
//   o_match     out  {received bits, i_bit} equals PASSWORD
// -----------------------------------------------------------------------------
module registro_clave
  import control_acceso_pkg::*;
#(
  parameter int                 PW_BITS  = DEF_PW_BITS,
  parameter logic [PW_BITS-1:0] PASSWORD = PW_BITS'(DEF_PASSWORD)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_shift_en,
  input  logic i_bit,
  output logic o_complete,
  output logic o_match
);

  // The bit counter only needs to reach PW_BITS-1: the final bit is never
  // stored, it is compared directly from the input on the completing edge.
  localparam int                CNT_W    = (PW_BITS > 2) ? $clog2(PW_BITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PW_BITS - 1);

  logic [PW_BITS-2:0] r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [PW_BITS-1:0] w_word;

  // Word as it would look after shifting in the current bit.
  assign w_word     = {r_shift, i_bit};
  assign o_complete = i_shift_en && (r_bit_cnt == CNT_LAST);
  assign o_match    = (w_word == PASSWORD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_clear) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_shift_en) begin
      r_shift   <= w_word[PW_BITS-2:0];
      // Completing edge restarts the count so a new attempt begins at once.
      r_bit_cnt <= o_complete ? '0 : r_bit_cnt + CNT_W'(1);
    end
  end

endmodule : registro_clave

// File: rtl/control_acceso_param.sv
// -----------------------------------------------------------------------------
// control_acceso_param
// Purpose : parking-gate access controller. A car at the gate (A) starts a
//           serial password entry (B qualified by B_valido). A correct word
//           opens the barrier; wrong words are counted and, after
//           MAX_INTENTOS failures, raise the PIN alarm. A second car entering
//           while the barrier is open (A and C together) locks the gate until
//           the password is re-entered. Idle entry sessions time out.
// Ports   :
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   A           in   car present at the gate
//   B           in   serial password bit, MSB first
//   B_valido    in   B is valid this cycle
//   C           in   car fully entered
//   Aguja       out  barrier open
//   Bloqueo     out  tailgating lock alarm
//   Alarma_pin  out  too many wrong passwords
//   intentos    out  current failed-attempt count
// -----------------------------------------------------------------------------
module control_acceso_param
  import control_acceso_pkg::*;
#(
  parameter int                 PW_BITS        = DEF_PW_BITS,
  parameter logic [PW_BITS-1:0] PASSWORD       = PW_BITS'(DEF_PASSWORD),
  parameter int                 MAX_INTENTOS   = DEF_MAX_INTENTOS,
  parameter int                 TIMEOUT_CICLOS = DEF_TIMEOUT_CICLOS
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              A,
  input  logic                              B,
  input  logic                              B_valido,
  input  logic                              C,
  output logic                              Aguja,
  output logic                              Bloqueo,
  output logic                              Alarma_pin,
  output logic [$clog2(MAX_INTENTOS+1)-1:0] intentos
);

  localparam int               INT_W   = $clog2(MAX_INTENTOS + 1);
  localparam logic [INT_W-1:0] INT_MAX = INT_W'(MAX_INTENTOS);
  // Threshold at which one more failure reaches the alarm.
  localparam logic [INT_W-1:0] INT_PRE = INT_W'(MAX_INTENTOS - 1);

  localparam int               TO_W    = $clog2(TIMEOUT_CICLOS);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CICLOS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [INT_W-1:0] r_intentos;
  logic [INT_W-1:0] w_intentos_next;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_to_cnt_next;

  logic             w_clear;
  logic             w_shift_en;
  logic             w_complete;
  logic             w_match;
  logic             w_accepts_bits;

  // Bits are taken in every state where a password is being typed; the open
  // state deliberately ignores the serial input.
  assign w_accepts_bits = (r_state == ST_INGRESO) ||
                          (r_state == ST_BLOQUEO) ||
                          (r_state == ST_ALARMA_PIN);
  assign w_shift_en     = B_valido && w_accepts_bits;

  registro_clave #(
    .PW_BITS  (PW_BITS),
    .PASSWORD (PASSWORD)
  ) u_registro_clave (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_clear    (w_clear),
    .i_shift_en (w_shift_en),
    .i_bit      (B),
    .o_complete (w_complete),
    .o_match    (w_match)
  );

  // State, attempt counter and idle-timeout counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_intentos <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_intentos <= w_intentos_next;
      r_to_cnt   <= w_to_cnt_next;
    end
  end

  // Next-state and counter logic. The timeout counter defaults to zero so it
  // is cleared everywhere except while INGRESO keeps waiting for a bit.
  always_comb begin
    w_state_next    = r_state;
    w_intentos_next = r_intentos;
    w_to_cnt_next   = '0;
    w_clear         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (A) begin
          w_state_next = ST_INGRESO;
          w_clear      = 1'b1;
        end
      end

      ST_INGRESO: begin
        // The car leaving wins over anything else arriving in the same cycle.
        if (!A) begin
          w_state_next = ST_IDLE;
        end else if (w_complete) begin
          if (w_match) begin
            w_state_next    = ST_ABIERTO;
            w_intentos_next = '0;
          end else if (r_intentos >= INT_PRE) begin
            w_state_next    = ST_ALARMA_PIN;
            w_intentos_next = INT_MAX;
          end else begin
            w_intentos_next = r_intentos + INT_W'(1);
          end
        end else if (!B_valido) begin
          if (r_to_cnt == TO_LAST) begin
            w_state_next = ST_IDLE;
          end else begin
            w_to_cnt_next = r_to_cnt + TO_W'(1);
          end
        end
      end

      ST_ABIERTO: begin
        if (A && C) begin
          w_state_next = ST_BLOQUEO;
        end else if (!A && C) begin
          w_state_next = ST_IDLE;
        end
      end

      ST_BLOQUEO: begin
        if (w_complete && w_match) begin
          w_state_next = ST_IDLE;
        end
      end

      ST_ALARMA_PIN: begin
        if (w_complete) begin
          if (w_match) begin
            w_state_next    = ST_IDLE;
            w_intentos_next = '0;
          end else begin
            w_intentos_next = INT_MAX;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Moore outputs: pure decode of registered state.
  assign Aguja      = (r_state == ST_ABIERTO);
  assign Bloqueo    = (r_state == ST_BLOQUEO);
  assign Alarma_pin = (r_state == ST_ALARMA_PIN);
  assign intentos   = r_intentos;

endmodule : control_acceso_param

// File: tb/tb_control_acceso_param.sv
// -----------------------------------------------------------------------------
// tb_control_acceso_param
// Purpose : self-checking bench for control_acceso_param with default
//           parameters. Each driven cycle queues the output vector expected
//           after the next rising edge; a monitor pops and compares it on the
//           following falling edge.
// -----------------------------------------------------------------------------
module tb_control_acceso_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       B_valido = 1'b0;
  logic       C = 1'b0;
  logic       Aguja;
  logic       Bloqueo;
  logic       Alarma_pin;
  logic [1:0] intentos;

  control_acceso_param #(
    .PW_BITS        (8),
    .PASSWORD       (8'b0011_1111),
    .MAX_INTENTOS   (3),
    .TIMEOUT_CICLOS (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .B_valido   (B_valido),
    .C          (C),
    .Aguja      (Aguja),
    .Bloqueo    (Bloqueo),
    .Alarma_pin (Alarma_pin),
    .intentos   (intentos)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         due;
    logic [4:0] exp;
    string      tag;
  } sb_item_t;

  sb_item_t   sb[$];
  sb_item_t   mon_item;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [4:0] e_cur = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected vector layout: {Aguja, Bloqueo, Alarma_pin, intentos[1:0]}
  function automatic logic [4:0] ev(bit ag, bit bl, bit al, int n);
    return {ag, bl, al, 2'(n)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor: only entries whose edge has already happened.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_item = sb.pop_front();
      chk(mon_item.tag, {27'd0, Aguja, Bloqueo, Alarma_pin, intentos}, {27'd0, mon_item.exp});
    end
  end

  // Drive one cycle (called just after a falling edge).
  task automatic step(bit a, bit bv, bit b, bit c, logic [4:0] exp, string tag);
    A        = a;
    B_valido = bv;
    B        = b;
    C        = c;
    sb.push_back('{due: cyc + 1, exp: exp, tag: tag});
    e_cur = exp;
    @(negedge clock);
  endtask

  task automatic send_word(logic [7:0] w, bit a, logic [4:0] last, string tag);
    for (int i = 7; i >= 0; i--) begin
      step(a, 1'b1, w[i], 1'b0, (i == 0) ? last : e_cur, tag);
    end
    $display("word %s 0x%02h -> ag=%0b bl=%0b al=%0b int=%0d",
             tag, w, last[4], last[3], last[2], last[1:0]);
  endtask

  // Send the n most significant bits of w, outputs expected unchanged.
  task automatic send_bits(logic [7:0] w, int n, bit a, string tag);
    for (int i = 7; i > 7 - n; i--) begin
      step(a, 1'b1, w[i], 1'b0, e_cur, tag);
    end
  endtask

  task automatic idle_cycles(int n, bit a, string tag);
    for (int i = 0; i < n; i++) begin
      step(a, 1'b0, 1'b0, 1'b0, e_cur, tag);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_outs", {27'd0, Aguja, Bloqueo, Alarma_pin, intentos}, 32'd0);
    reset = 1'b1;

    // Correct password opens, car passes and leaves
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t1_enter");
    send_word(8'h3F, 1, ev(1, 0, 0, 0), "t1_pw");
    step(1, 1, 1, 0, ev(1, 0, 0, 0), "t1_hold");
    step(0, 0, 0, 1, ev(0, 0, 0, 0), "t1_exit");

    // Three wrong words -> PIN alarm; wrong word in alarm saturates; right clears
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t2_enter");
    send_word(8'hFF, 1, ev(0, 0, 0, 1), "t2_bad1");
    send_word(8'hFF, 1, ev(0, 0, 0, 2), "t2_bad2");
    send_word(8'hFF, 1, ev(0, 0, 1, 3), "t2_bad3");
    send_word(8'h00, 1, ev(0, 0, 1, 3), "t2_alarm_bad");
    send_word(8'h3F, 1, ev(0, 0, 0, 0), "t2_alarm_ok");

    // Tailgating lock, wrong word keeps it, right word releases
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t3_enter");
    send_word(8'hFF, 1, ev(0, 0, 0, 1), "t3_bad");
    send_word(8'h3F, 1, ev(1, 0, 0, 0), "t3_pw");
    step(1, 0, 0, 1, ev(0, 1, 0, 0), "t3_tailgate");
    send_word(8'hAA, 1, ev(0, 1, 0, 0), "t3_lock_bad");
    send_word(8'h3F, 0, ev(0, 0, 0, 0), "t3_lock_ok");
    step(0, 0, 0, 0, ev(0, 0, 0, 0), "t3_idle");

    // 15 idle cycles do not time out: 3 bits + gap + 5 bits form one word
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t4a_enter");
    send_word(8'hFF, 1, ev(0, 0, 0, 1), "t4a_bad");
    send_bits(8'h3F, 3, 1, "t4a_part");
    idle_cycles(15, 1, "t4a_gap15");
    send_bits(8'hFF, 4, 1, "t4a_rest");
    step(1, 1, 1, 0, ev(1, 0, 0, 0), "t4a_last");
    step(0, 0, 0, 1, ev(0, 0, 0, 0), "t4a_exit");

    // 16 idle cycles time out; partial bits discarded, intentos kept
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t4b_enter");
    send_word(8'hFF, 1, ev(0, 0, 0, 1), "t4b_bad");
    send_bits(8'h3F, 3, 1, "t4b_part");
    idle_cycles(16, 1, "t4b_gap16");
    step(1, 0, 0, 0, ev(0, 0, 0, 1), "t4b_reenter");
    send_word(8'h3F, 1, ev(1, 0, 0, 0), "t4b_pw");
    step(0, 0, 0, 1, ev(0, 0, 0, 0), "t4b_exit");

    // Car leaves after 5 bits: partial discarded, nothing counted
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t4c_enter");
    send_bits(8'hFF, 5, 1, "t4c_part");
    step(0, 0, 0, 0, ev(0, 0, 0, 0), "t4c_leave");
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t4c_reenter");
    send_word(8'h3F, 1, ev(1, 0, 0, 0), "t4c_pw");
    step(0, 0, 0, 1, ev(0, 0, 0, 0), "t4c_exit");

    // A=0 on the completing wrong bit wins: no attempt counted
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t4d_enter");
    send_bits(8'hFF, 7, 1, "t4d_part");
    step(0, 1, 1, 0, ev(0, 0, 0, 0), "t4d_leave_on_last");
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t4d_reenter");
    send_word(8'h3F, 1, ev(1, 0, 0, 0), "t4d_pw");
    step(0, 0, 0, 1, ev(0, 0, 0, 0), "t4d_exit");

    // Asynchronous reset mid-attempt
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t5_enter");
    send_word(8'hFF, 1, ev(0, 0, 0, 1), "t5_bad");
    send_bits(8'h3F, 6, 1, "t5_part");
    drain();
    #2 reset = 1'b0;
    #1 chk("t5_async_rst", {27'd0, Aguja, Bloqueo, Alarma_pin, intentos}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step(1, 0, 0, 0, ev(0, 0, 0, 0), "t5_enter2");
    send_word(8'h3F, 1, ev(1, 0, 0, 0), "t5_pw");
    step(0, 0, 0, 1, ev(0, 0, 0, 0), "t5_exit");

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_control_acceso_param
